// File: rtl/purse_controller.sv
// Battle wallet: periodic income, deploy/upgrade charging against external cost tables,
// and clamping of the balance to the capacity of the current purse level.
module purse_controller #(
  parameter int TICK_CYCLES = 10_000_000,
  parameter int INC_BASE    = 5,
  parameter int INC_STEP    = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        game_clr,
  input  logic        deploy_req,
  input  logic [2:0]  deploy_type,
  input  logic        upgrade_req,
  output logic [2:0]  cost_addr,
  input  logic [14:0] cost_in,
  output logic [2:0]  purse_level,
  input  logic [14:0] upg_cost_in,
  input  logic [14:0] max_money_in,
  output logic        deploy_ack,
  output logic        deploy_nak,
  output logic        upgrade_ack,
  output logic        upgrade_nak,
  output logic [14:0] money
);

  localparam int              CNT_W     = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_CYCLES - 1);
  localparam logic [2:0]      LEVEL_MAX = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DEP  = 2'd1,
    UPG  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             deploy_req_p1;
  logic             upgrade_req_p1;
  logic             deploy_edge;
  logic             upgrade_edge;
  logic [CNT_W-1:0] tick_cnt;
  logic             tick;
  logic             dep_ok;
  logic             upg_ok;
  logic [15:0]      spend;
  logic [15:0]      income;
  logic [14:0]      money_nxt;

  function automatic logic [15:0] income_for(input logic [2:0] lvl);
    return 16'(INC_BASE) + 16'(INC_STEP) * {13'd0, lvl};
  endfunction

  // Clamp a 16-bit intermediate balance to the purse capacity.
  function automatic logic [14:0] sat_money(input logic [15:0] v, input logic [14:0] cap);
    if (v > {1'b0, cap}) return cap;
    return v[14:0];
  endfunction

  assign deploy_edge  = en && deploy_req  && !deploy_req_p1;
  assign upgrade_edge = en && upgrade_req && !upgrade_req_p1;
  assign tick         = en && (tick_cnt == CNT_LAST);

  // Affordability is judged on the balance before any income of this cycle.
  assign dep_ok = (state == DEP) && (money >= cost_in);
  assign upg_ok = (state == UPG) && (purse_level != LEVEL_MAX) && (money >= upg_cost_in);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (deploy_edge)       state_nxt = DEP;
        else if (upgrade_edge) state_nxt = UPG;
      end
      DEP:     state_nxt = IDLE;
      UPG:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    spend = 16'd0;
    if (dep_ok)      spend = {1'b0, cost_in};
    else if (upg_ok) spend = {1'b0, upg_cost_in};
  end

  // Income uses the pre-upgrade level; capacity is the pre-upgrade table output.
  assign income    = tick ? income_for(purse_level) : 16'd0;
  assign money_nxt = sat_money({1'b0, money} - spend + income, max_money_in);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      deploy_req_p1  <= 1'b0;
      upgrade_req_p1 <= 1'b0;
      tick_cnt       <= '0;
      cost_addr      <= 3'd0;
      purse_level    <= 3'd0;
      money          <= 15'd0;
      deploy_ack     <= 1'b0;
      deploy_nak     <= 1'b0;
      upgrade_ack    <= 1'b0;
      upgrade_nak    <= 1'b0;
    end else if (game_clr) begin
      state          <= IDLE;
      deploy_req_p1  <= 1'b0;
      upgrade_req_p1 <= 1'b0;
      tick_cnt       <= '0;
      cost_addr      <= 3'd0;
      purse_level    <= 3'd0;
      money          <= 15'd0;
      deploy_ack     <= 1'b0;
      deploy_nak     <= 1'b0;
      upgrade_ack    <= 1'b0;
      upgrade_nak    <= 1'b0;
    end else begin
      deploy_req_p1  <= deploy_req;
      upgrade_req_p1 <= upgrade_req;
      state          <= state_nxt;
      if (en) tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
      if ((state == IDLE) && deploy_edge) cost_addr <= deploy_type;
      money          <= money_nxt;
      if (upg_ok) purse_level <= purse_level + 3'd1;
      deploy_ack     <= dep_ok;
      deploy_nak     <= (state == DEP) && !dep_ok;
      upgrade_ack    <= upg_ok;
      upgrade_nak    <= (state == UPG) && !upg_ok;
    end
  end

endmodule
